hp_tracker: RTL and testbench

Per-round health bookkeeping for both fighters. Consumes hit events from the collision/attack logic and drives the player_hp1/player_hp2 values that the HP-bar renderer reads. Sequences the round (idle, fight, KO hold) and applies per-player invulnerability windows counted in video frames.

---
 rtl/hp_tracker.sv | 81 ++++++++
 tb/tb_hp_tracker.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hp_tracker.sv
// hp_tracker: round sequencing, saturating HP bookkeeping and per-player invulnerability for two fighters.
module hp_tracker #(
  parameter int MAX_HP         = 200,
  parameter int INVULN_FRAMES  = 30,
  parameter int KO_HOLD_FRAMES = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       hit1,
  input  logic [7:0] dmg1,
  input  logic       hit2,
  input  logic [7:0] dmg2,
  output logic [9:0] player_hp1,
  output logic [9:0] player_hp2,
  output logic       invuln1,
  output logic       invuln2,
  output logic       fighting,
  output logic       round_over,
  output logic [1:0] winner
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FIGHT = 2'd1;
  localparam logic [1:0] KO    = 2'd2;
  localparam logic [9:0] HP0     = 10'(MAX_HP);
  localparam logic [7:0] INV0    = 8'(INVULN_FRAMES);
  localparam logic [9:0] KO_LAST = 10'(KO_HOLD_FRAMES - 1);
  logic [1:0] state;
  logic [7:0] inv_cnt1, inv_cnt2, dec1, dec2;
  logic [9:0] ko_cnt, nhp1, nhp2;
  logic       acc1, acc2, ko;
  always_comb begin
    acc1 = (state == FIGHT) && hit1 && (inv_cnt1 == 8'd0);
    acc2 = (state == FIGHT) && hit2 && (inv_cnt2 == 8'd0);
    nhp1 = acc1 ? ((player_hp1 > {2'b0, dmg1}) ? player_hp1 - {2'b0, dmg1} : 10'd0) : player_hp1;
    nhp2 = acc2 ? ((player_hp2 > {2'b0, dmg2}) ? player_hp2 - {2'b0, dmg2} : 10'd0) : player_hp2;
    dec1 = (frame_tick && inv_cnt1 != 8'd0) ? inv_cnt1 - 8'd1 : inv_cnt1;
    dec2 = (frame_tick && inv_cnt2 != 8'd0) ? inv_cnt2 - 8'd1 : inv_cnt2;
    ko   = (state == FIGHT) && (nhp1 == 10'd0 || nhp2 == 10'd0);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      player_hp1 <= HP0;
      player_hp2 <= HP0;
      inv_cnt1   <= 8'd0;
      inv_cnt2   <= 8'd0;
      ko_cnt     <= 10'd0;
      winner     <= 2'b00;
    end else if (state == IDLE) begin
      if (start) state <= FIGHT;
    end else if (state == FIGHT) begin
      player_hp1 <= nhp1;
      player_hp2 <= nhp2;
      if (ko) begin
        state    <= KO;
        winner   <= {nhp1 == 10'd0, nhp2 == 10'd0};
        inv_cnt1 <= 8'd0;
        inv_cnt2 <= 8'd0;
      end else begin
        inv_cnt1 <= acc1 ? INV0 : dec1;
        inv_cnt2 <= acc2 ? INV0 : dec2;
      end
    end else if (frame_tick) begin
      if (ko_cnt == KO_LAST) begin
        state      <= IDLE;
        player_hp1 <= HP0;
        player_hp2 <= HP0;
        winner     <= 2'b00;
        ko_cnt     <= 10'd0;
      end else begin
        ko_cnt <= ko_cnt + 10'd1;
      end
    end
  end
  assign invuln1    = inv_cnt1 != 8'd0;
  assign invuln2    = inv_cnt2 != 8'd0;
  assign fighting   = state == FIGHT;
  assign round_over = state == KO;
endmodule

// File: tb/tb_hp_tracker.sv
// tb_hp_tracker: directed round scenarios; expectations queued with each stimulus step and checked after the edge.
module tb_hp_tracker;
  logic       Clk = 0, Reset = 1, frame_tick = 0, start = 0, hit1 = 0, hit2 = 0;
  logic [7:0] dmg1 = 0, dmg2 = 0;
  logic [9:0] player_hp1, player_hp2;
  logic       invuln1, invuln2, fighting, round_over;
  logic [1:0] winner;
  int checks = 0, errors = 0;
  localparam int H1 = 0, H2 = 1, I1 = 2, I2 = 3, FI = 4, RO = 5, WI = 6;
  string       tq[$];
  int          sq[$];
  logic [31:0] eq[$];

  hp_tracker dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
    .hit1(hit1), .dmg1(dmg1), .hit2(hit2), .dmg2(dmg2),
    .player_hp1(player_hp1), .player_hp2(player_hp2),
    .invuln1(invuln1), .invuln2(invuln2), .fighting(fighting),
    .round_over(round_over), .winner(winner)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] obs(input int sel);
    return sel == H1 ? 32'(player_hp1) : sel == H2 ? 32'(player_hp2) :
           sel == I1 ? 32'(invuln1)    : sel == I2 ? 32'(invuln2)    :
           sel == FI ? 32'(fighting)   : sel == RO ? 32'(round_over) : 32'(winner);
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    tq.push_back(tag);
    sq.push_back(sel);
    eq.push_back(e);
  endtask

  task automatic check();
    while (sq.size() > 0) begin
      string       t = tq.pop_front();
      int          s = sq.pop_front();
      logic [31:0] e = eq.pop_front();
      logic [31:0] o = obs(s);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", t, o, e);
      end
    end
  endtask

  task automatic cyc(input logic h1, input logic [7:0] d1, input logic h2, input logic [7:0] d2,
                     input logic ft, input logic st, input logic rs);
    hit1 = h1; dmg1 = d1; hit2 = h2; dmg2 = d2; frame_tick = ft; start = st; Reset = rs;
    @(posedge Clk);
    #1;
    hit1 = 0; dmg1 = 0; hit2 = 0; dmg2 = 0; frame_tick = 0; start = 0; Reset = 0;
    check();
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    push("rst_hp1", H1, 200); push("rst_hp2", H2, 200); push("rst_inv1", I1, 0);
    push("rst_inv2", I2, 0); push("rst_fight", FI, 0); push("rst_ko", RO, 0); push("rst_win", WI, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    push("idle_hit_hp1", H1, 200); push("idle_hit_fight", FI, 0);
    cyc(1, 50, 0, 0, 0, 0, 0);
    push("start_fight", FI, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    push("hit_hp1", H1, 150); push("hit_inv1", I1, 1); push("hit_hp2", H2, 200);
    push("hit_fight", FI, 1); push("hit_win", WI, 0);
    cyc(1, 50, 0, 0, 0, 0, 0);
    ticks(10);
    push("rej_hp1", H1, 150);
    cyc(1, 50, 0, 0, 0, 0, 0);
    ticks(18);
    push("inv29_inv1", I1, 1);
    ticks(1);
    push("inv30_inv1", I1, 0);
    ticks(1);
    push("rehit_hp1", H1, 100); push("rehit_inv1", I1, 1);
    cyc(1, 50, 0, 0, 0, 0, 0);
    ticks(25);
    push("rej_tick_hp1", H1, 100);
    cyc(1, 50, 0, 0, 1, 0, 0);
    ticks(2);
    push("cnt4_left1", I1, 1);
    ticks(1);
    push("cnt4_zero", I1, 0);
    ticks(1);
    push("acc_tick_hp1", H1, 100); push("acc_tick_inv1", I1, 1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    ticks(28);
    push("load30_left1", I1, 1);
    ticks(1);
    push("load30_zero", I1, 0);
    ticks(1);
    push("hp2_20", H2, 20); push("hp2_inv2", I2, 1);
    cyc(0, 0, 1, 180, 0, 0, 0);
    ticks(30);
    push("sat_hp2", H2, 0); push("sat_win", WI, 1); push("sat_ko", RO, 1); push("sat_fight", FI, 0);
    push("sat_inv1", I1, 0); push("sat_inv2", I2, 0); push("sat_hp1", H1, 100);
    cyc(0, 0, 1, 255, 0, 0, 0);
    push("ko_start_ko", RO, 1); push("ko_start_fight", FI, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    push("ko_hit_hp1", H1, 100);
    cyc(1, 50, 0, 0, 0, 0, 0);
    ticks(118);
    push("hold119_ko", RO, 1); push("hold119_win", WI, 1);
    ticks(1);
    push("hold120_ko", RO, 0); push("hold120_win", WI, 0); push("hold120_hp1", H1, 200);
    push("hold120_hp2", H2, 200); push("hold120_fight", FI, 0);
    ticks(1);
    push("draw_start", FI, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    push("both_hp1", H1, 10); push("both_hp2", H2, 10);
    cyc(1, 190, 1, 190, 0, 0, 0);
    ticks(30);
    push("draw_hp1", H1, 0); push("draw_hp2", H2, 0); push("draw_win", WI, 3); push("draw_ko", RO, 1);
    cyc(1, 10, 1, 10, 0, 0, 0);
    push("ko_rst_hp1", H1, 200); push("ko_rst_ko", RO, 0); push("ko_rst_win", WI, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    push("p2win_hp1", H1, 0); push("p2win_win", WI, 2); push("p2win_ko", RO, 1);
    cyc(1, 255, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    push("pre_rst_hp1", H1, 80); push("pre_rst_inv1", I1, 1);
    cyc(1, 120, 0, 0, 0, 0, 0);
    push("mid_rst_hp1", H1, 200); push("mid_rst_inv1", I1, 0); push("mid_rst_fight", FI, 0);
    push("mid_rst_win", WI, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    push("post_rst_hit_hp1", H1, 200);
    cyc(1, 50, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
